// File: rtl/mem_demux.sv
`default_nettype none
//============================================================================
// Module      : mem_demux
// Description : Single-outstanding request demultiplexer. One upstream
//               request is registered, routed to one of two downstream
//               memory ports by address region, and the selected port's
//               response is returned upstream as a one-cycle strobe.
//
// Ports       :
//   clk, rst            clock (rising edge) / asynchronous active-high reset
//   req_valid/ready     upstream request handshake (ready only in IDLE)
//   req_addr/wdata/we   upstream request payload
//   m_addr/wdata/we     registered payload shared by both ports
//   m0_valid/m1_valid   per-port request strobe (only in ISSUE)
//   m0_ready/m1_ready   per-port request accept
//   m0_/m1_rsp_valid    per-port response strobe
//   m0_/m1_rdata        per-port response data
//   rsp_valid           one-cycle upstream response strobe
//   rsp_rdata           upstream response data (held until next response)
//   rsp_err             response was produced by a timeout
//
// Parameters  :
//   M1_REGION       req_addr[31:28] value that selects port 1
//   TIMEOUT_CYCLES  WAIT cycles before a timeout response
//
// Build option:
//   MEM_DEMUX_TIMEOUT_EN  when defined, adds the WAIT-state timeout counter.
//                         When undefined, WAIT is unbounded and rsp_err=0.
//
// Revision    : 1.0 - initial release
//============================================================================
module mem_demux #(
    parameter logic [3:0] M1_REGION      = 4'hF,
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    // upstream request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    // shared downstream payload
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_we,
    // port 0
    output logic        m0_valid,
    input  logic        m0_ready,
    input  logic        m0_rsp_valid,
    input  logic [31:0] m0_rdata,
    // port 1
    output logic        m1_valid,
    input  logic        m1_ready,
    input  logic        m1_rsp_valid,
    input  logic [31:0] m1_rdata,
    // upstream response
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_sel;      // 1 = port 1 selected for the current transaction
    logic [31:0] r_rdata;

    logic        w_port_ready;
    logic        w_rsp_hit;
    logic [31:0] w_rsp_data;
    logic        w_accept;
    logic        w_issue_done;
    logic        w_timeout;

    // Only the selected port's strobes are ever looked at.
    assign w_port_ready = r_sel ? m1_ready     : m0_ready;
    assign w_rsp_data   = r_sel ? m1_rdata     : m0_rdata;
    assign w_rsp_hit    = (r_state == S_WAIT) && (r_sel ? m1_rsp_valid : m0_rsp_valid);
    assign w_accept     = (r_state == S_IDLE) && req_valid && !rst;
    assign w_issue_done = (r_state == S_ISSUE) && w_port_ready;

`ifdef MEM_DEMUX_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_err;

    // Counter holds the number of completed WAIT cycles; the timeout fires in
    // the WAIT cycle numbered TIMEOUT_CYCLES so a response arriving in that
    // same cycle can still take priority.
    assign w_timeout = (r_state == S_WAIT) && (r_cnt == (TIMEOUT_CYCLES - 8'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            if (w_issue_done) begin
                r_cnt <= 8'd0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_rsp_hit) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rsp_err = r_err;
`else
    // Timeout length is irrelevant when no counter is built.
    logic w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    //------------------------------------------------------------------------
    // Next state and control outputs
    //------------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        m0_valid  = 1'b0;
        m1_valid  = 1'b0;
        rsp_valid = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Ready is masked by rst so it reads 0 throughout reset even
                // though the state register already sits in IDLE.
                req_ready = !rst;
                if (req_valid) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                m0_valid = !r_sel;
                m1_valid = r_sel;
                if (w_port_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_rsp_hit || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Request payload and response data registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_sel   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_we    <= req_we;
                r_sel   <= (req_addr[31:28] == M1_REGION);
            end

            // Data is captured for writes too; upstream sees whatever the
            // port returned.
            if (w_rsp_hit) begin
                r_rdata <= w_rsp_data;
            end else if (w_timeout) begin
                r_rdata <= 32'hDEAD_BEEF;
            end
        end
    end

    assign m_addr    = r_addr;
    assign m_wdata   = r_wdata;
    assign m_we      = r_we;
    assign rsp_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_demux.sv
`default_nettype none
//============================================================================
// Module      : tb_mem_demux
// Description : Directed self-checking bench for mem_demux. Inputs change
//               and outputs are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mem_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic        m0_valid;
    logic        m0_ready;
    logic        m0_rsp_valid;
    logic [31:0] m0_rdata;
    logic        m1_valid;
    logic        m1_ready;
    logic        m1_rsp_valid;
    logic [31:0] m1_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_demux dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_we       (req_we),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_we         (m_we),
        .m0_valid     (m0_valid),
        .m0_ready     (m0_ready),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rdata     (m0_rdata),
        .m1_valid     (m1_valid),
        .m1_ready     (m1_ready),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rdata     (m1_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge while IDLE; returns on the falling edge of the
    // first ISSUE cycle.
    task automatic send_req(input logic [31:0] a, input logic [31:0] d, input logic we);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_we    = we;
        cyc(1);
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_we    = 1'b0;
    endtask

    // Safety net against a hung run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int hits;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_we       = 1'b0;
        m0_ready     = 1'b0;
        m0_rsp_valid = 1'b0;
        m0_rdata     = 32'h0;
        m1_ready     = 1'b0;
        m1_rsp_valid = 1'b0;
        m1_rdata     = 32'h0;

        // ---------------- reset state ----------------
        cyc(2);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_m0_valid",  {31'd0, m0_valid},  32'd0);
        check("rst_m1_valid",  {31'd0, m1_valid},  32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("rst_m_addr",    m_addr,             32'd0);
        check("rst_m_wdata",   m_wdata,            32'd0);
        check("rst_m_we",      {31'd0, m_we},      32'd0);
        check("rst_rsp_rdata", rsp_rdata,          32'd0);
        rst = 1'b0;
        cyc(1);
        check("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // ---------------- read to port 0, minimum latency ----------------
        m0_ready = 1'b1;
        send_req(32'h0000_0010, 32'h0, 1'b0);
        check("t1_issue_m0_valid",  {31'd0, m0_valid},  32'd1);
        check("t1_issue_m1_valid",  {31'd0, m1_valid},  32'd0);
        check("t1_issue_m_addr",    m_addr,             32'h0000_0010);
        check("t1_issue_m_we",      {31'd0, m_we},      32'd0);
        check("t1_issue_req_ready", {31'd0, req_ready}, 32'd0);
        cyc(1);
        check("t1_wait_m0_valid",  {31'd0, m0_valid},  32'd0);
        check("t1_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        m0_rsp_valid = 1'b1;
        m0_rdata     = 32'h1234_5678;
        cyc(1);
        m0_rsp_valid = 1'b0;
        m0_rdata     = 32'h0;
        check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t1_rsp_rdata", rsp_rdata,          32'h1234_5678);
        check("t1_rsp_err",   {31'd0, rsp_err},   32'd0);
        cyc(1);
        check("t1_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("t1_idle_req_ready", {31'd0, req_ready}, 32'd1);
        check("t1_idle_rdata_hold", rsp_rdata,         32'h1234_5678);

        // ---------------- write to port 1 with back-pressure ----------------
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        send_req(32'hF000_0004, 32'hCAFE_0001, 1'b1);
        // A response strobe during ISSUE must be ignored.
        m1_rsp_valid = 1'b1;
        m1_rdata     = 32'h1111_1111;
        for (int i = 0; i < 4; i++) begin
            check("t2_stall_m1_valid",  {31'd0, m1_valid},  32'd1);
            check("t2_stall_m0_valid",  {31'd0, m0_valid},  32'd0);
            check("t2_stall_m_addr",    m_addr,             32'hF000_0004);
            check("t2_stall_m_wdata",   m_wdata,            32'hCAFE_0001);
            check("t2_stall_m_we",      {31'd0, m_we},      32'd1);
            check("t2_stall_req_ready", {31'd0, req_ready}, 32'd0);
            check("t2_stall_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            cyc(1);
        end
        m1_rsp_valid = 1'b0;
        m1_rdata     = 32'h0;
        check("t2_hs_m1_valid", {31'd0, m1_valid}, 32'd1);
        m1_ready = 1'b1;
        cyc(1);
        m1_ready = 1'b0;
        check("t2_wait_m1_valid",  {31'd0, m1_valid},  32'd0);
        check("t2_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        m1_rsp_valid = 1'b1;
        m1_rdata     = 32'h0000_00AA;
        cyc(1);
        m1_rsp_valid = 1'b0;
        m1_rdata     = 32'h0;
        check("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t2_rsp_rdata", rsp_rdata,          32'h0000_00AA);
        cyc(1);
        check("t2_single_rsp",   {31'd0, rsp_valid}, 32'd0);
        check("t2_m_addr_hold",  m_addr,             32'hF000_0004);
        check("t2_m_wdata_hold", m_wdata,            32'hCAFE_0001);
        check("t2_m_we_hold",    {31'd0, m_we},      32'd1);

        // ---------------- spurious response from the other port ----------------
        m0_ready = 1'b1;
        send_req(32'h0000_0020, 32'h0, 1'b0);
        cyc(1);
        m0_ready     = 1'b0;
        m1_rsp_valid = 1'b1;
        m1_rdata     = 32'hBAD0_BAD0;
        cyc(1);
        m1_rsp_valid = 1'b0;
        m1_rdata     = 32'h0;
        check("t3_spurious_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        m0_rsp_valid = 1'b1;
        m0_rdata     = 32'h55AA_0033;
        cyc(1);
        m0_rsp_valid = 1'b0;
        m0_rdata     = 32'h0;
        check("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t3_rsp_rdata", rsp_rdata,          32'h55AA_0033);
        cyc(1);

        // ---------------- reset during WAIT ----------------
        m0_ready = 1'b1;
        send_req(32'h0000_0030, 32'h0, 1'b0);
        cyc(1);
        m0_ready = 1'b0;
        rst      = 1'b1;
        #1;
        check("t4_rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("t4_rst_rsp_rdata", rsp_rdata,          32'd0);
        check("t4_rst_m_addr",    m_addr,             32'd0);
        cyc(1);
        rst          = 1'b0;
        m0_rsp_valid = 1'b1;
        m0_rdata     = 32'h7777_7777;
        cyc(1);
        check("t4_late_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("t4_req_ready",      {31'd0, req_ready}, 32'd1);
        cyc(1);
        m0_rsp_valid = 1'b0;
        m0_rdata     = 32'h0;
        check("t4_late_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
        check("t4_late_rdata",      rsp_rdata,          32'd0);
        m0_ready = 1'b1;
        send_req(32'h0000_0040, 32'h0, 1'b0);
        check("t4_next_m0_valid", {31'd0, m0_valid}, 32'd1);
        cyc(1);
        m0_ready     = 1'b0;
        m0_rsp_valid = 1'b1;
        m0_rdata     = 32'h9999_0001;
        cyc(1);
        m0_rsp_valid = 1'b0;
        m0_rdata     = 32'h0;
        check("t4_next_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t4_next_rsp_rdata", rsp_rdata,          32'h9999_0001);
        cyc(1);

`ifdef MEM_DEMUX_TIMEOUT_EN
        // ---------------- timeout after 255 WAIT cycles ----------------
        m1_ready = 1'b1;
        send_req(32'hF000_0100, 32'h0, 1'b0);
        cyc(1);
        m1_ready = 1'b0;
        hits     = 0;
        for (int k = 1; k < 255; k++) begin
            if (rsp_valid) hits++;
            cyc(1);
        end
        if (rsp_valid) hits++;
        check("t5_no_early_rsp", hits, 32'd0);
        cyc(1);
        check("t5_to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t5_to_rsp_err",   {31'd0, rsp_err},   32'd1);
        check("t5_to_rsp_rdata", rsp_rdata,          32'hDEAD_BEEF);
        cyc(1);

        // Response in the same cycle the timeout would fire.
        m1_ready = 1'b1;
        send_req(32'hF000_0200, 32'h0, 1'b0);
        cyc(1);
        m1_ready = 1'b0;
        cyc(254);
        m1_rsp_valid = 1'b1;
        m1_rdata     = 32'h0F0F_0F0F;
        cyc(1);
        m1_rsp_valid = 1'b0;
        m1_rdata     = 32'h0;
        check("t5_race_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t5_race_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("t5_race_rsp_rdata", rsp_rdata,          32'h0F0F_0F0F);
        cyc(1);
`else
        // ---------------- unbounded WAIT without timeout ----------------
        m1_ready = 1'b1;
        send_req(32'hF000_0100, 32'h0, 1'b0);
        cyc(1);
        m1_ready = 1'b0;
        hits     = 0;
        for (int k = 0; k < 300; k++) begin
            if (rsp_valid) hits++;
            cyc(1);
        end
        check("t5_no_timeout_rsp", hits, 32'd0);
        m1_rsp_valid = 1'b1;
        m1_rdata     = 32'hABCD_0123;
        cyc(1);
        m1_rsp_valid = 1'b0;
        m1_rdata     = 32'h0;
        check("t5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t5_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("t5_rsp_rdata", rsp_rdata,          32'hABCD_0123);
        cyc(1);
`endif

        check("end_req_ready", {31'd0, req_ready}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
